// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read port, occupancy counter and status flags.
// Optional sticky OVERFLOW/UNDERFLOW logic is built only when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  input  logic                  ERR_CLR,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  full_d, empty_d, afull_d, aempty_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q;
  logic                  wr_acc, rd_acc;

  // Accept logic, pointer/count next state; flags are pre-decoded from the next count
  always_comb begin
    rd_acc    = RD_EN & ~empty_q;
    wr_acc    = WR_EN & (~full_q | rd_acc);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == CW'(0));
    afull_d  = (count_d >= CW'(AFULL_TH));
    aempty_d = (count_d <= CW'(AEMPTY_TH));
  end

  // Control and status registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= (AFULL_TH == 0);
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_acc;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
    end
  end

  // Storage array, deliberately not reset; a write while full lands in the slot read this cycle
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) begin
      mem_q[wr_ptr_q] <= WR_DATA;
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky error next state: a new error wins over a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (WR_EN & full_q & ~rd_acc) begin
      ovf_d = 1'b1;
    end else if (ERR_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (RD_EN & empty_q) begin
      udf_d = 1'b1;
    end else if (ERR_CLR) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Sticky error registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = ERR_CLR;
  assign OVERFLOW       = 1'b0;
  assign UNDERFLOW      = 1'b0;
`endif

  assign RD_DATA      = rd_data_q;
  assign RD_VALID     = rd_valid_q;
  assign COUNT        = count_q;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
endmodule

// File: tb/tb_sync_fifo_buf.sv
// Bench for sync_fifo_buf: a default 8-deep instance and a 16-deep instance share stimulus,
// each checked against a queue model and a read-data scoreboard; the 8-deep one also against a table.
module tb_sync_fifo_buf;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] wr_data;

  logic [7:0] rdd1, rdd2;
  logic [3:0] cnt1;
  logic [4:0] cnt2;
  logic       vld1, full1, empty1, af1, ae1, ovf1, udf1;
  logic       vld2, full2, empty2, af2, ae2, ovf2, udf2;

  sync_fifo_buf u_dut1 (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rdd1), .RD_VALID(vld1), .FULL(full1), .EMPTY(empty1),
    .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .COUNT(cnt1), .ERR_CLR(err_clr),
    .OVERFLOW(ovf1), .UNDERFLOW(udf1)
  );

  sync_fifo_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_TH(12), .AEMPTY_TH(3)) u_dut2 (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_DATA(wr_data), .RD_EN(rd_en),
    .RD_DATA(rdd2), .RD_VALID(vld2), .FULL(full2), .EMPTY(empty2),
    .ALMOST_FULL(af2), .ALMOST_EMPTY(ae2), .COUNT(cnt2), .ERR_CLR(err_clr),
    .OVERFLOW(ovf2), .UNDERFLOW(udf2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  logic [7:0] mq [2][$];
  logic [7:0] sbq [2][$];
  logic [7:0] mdata [2];
  logic       mvalid [2];
  logic       movf [2];
  logic       mudf [2];

  typedef struct {
    logic       rst, wr, rd;
    logic [7:0] wd;
    int         cnt;
    logic       full, empty, af, ae, vld;
    logic [7:0] rdd;
  } vec_t;
  vec_t tbl [22];

  function automatic vec_t mk(input logic r, w, rd, input logic [7:0] wd, input int cnt,
                              input logic fu, em, af, ae, vl, input logic [7:0] rdd);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.wd = wd; v.cnt = cnt;
    v.full = fu; v.empty = em; v.af = af; v.ae = ae; v.vld = vl; v.rdd = rdd;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_step(input int d);
    int depth, sz;
    logic rd_ok, wr_ok;
    depth = (d == 0) ? 8 : 16;
    if (rst) begin
      mq[d].delete();
      sbq[d].delete();
      mdata[d] = 8'h00; mvalid[d] = 1'b0; movf[d] = 1'b0; mudf[d] = 1'b0;
    end else begin
      sz    = mq[d].size();
      rd_ok = rd_en && (sz > 0);
      wr_ok = wr_en && ((sz < depth) || rd_ok);
      if (ERR_ON) begin
        if (wr_en && (sz == depth) && !rd_ok) movf[d] = 1'b1;
        else if (err_clr) movf[d] = 1'b0;
        if (rd_en && (sz == 0)) mudf[d] = 1'b1;
        else if (err_clr) mudf[d] = 1'b0;
      end
      mvalid[d] = rd_ok;
      if (rd_ok) begin
        mdata[d] = mq[d].pop_front();
        sbq[d].push_back(mdata[d]);
      end
      if (wr_ok) mq[d].push_back(wr_data);
    end
  endtask

  task automatic compare(input int d);
    int sz, afth, aeth, depth;
    int c, f, e, a, ae, v, rd, ov, ud;
    logic [7:0] exp_d;
    depth = (d == 0) ? 8 : 16;
    afth  = (d == 0) ? 6 : 12;
    aeth  = (d == 0) ? 2 : 3;
    sz    = mq[d].size();
    if (d == 0) begin
      c = cnt1; f = full1; e = empty1; a = af1; ae = ae1; v = vld1; rd = rdd1; ov = ovf1; ud = udf1;
    end else begin
      c = cnt2; f = full2; e = empty2; a = af2; ae = ae2; v = vld2; rd = rdd2; ov = ovf2; ud = udf2;
    end
    chk($sformatf("d%0d count", d), c, sz);
    chk($sformatf("d%0d full", d), f, int'(sz == depth));
    chk($sformatf("d%0d empty", d), e, int'(sz == 0));
    chk($sformatf("d%0d almost_full", d), a, int'(sz >= afth));
    chk($sformatf("d%0d almost_empty", d), ae, int'(sz <= aeth));
    chk($sformatf("d%0d rd_valid", d), v, int'(mvalid[d]));
    chk($sformatf("d%0d rd_data", d), rd, int'(mdata[d]));
    chk($sformatf("d%0d overflow", d), ov, int'(movf[d]));
    chk($sformatf("d%0d underflow", d), ud, int'(mudf[d]));
    if (v != 0) begin
      if (sbq[d].size() == 0) begin
        chk($sformatf("d%0d sb_unexpected_pop", d), 1, 0);
      end else begin
        exp_d = sbq[d].pop_front();
        chk($sformatf("d%0d sb_data", d), rd, int'(exp_d));
      end
    end
  endtask

  task automatic cycle(input logic r, w, rd, input logic [7:0] d, input logic c);
    rst = r; wr_en = w; rd_en = rd; wr_data = d; err_clr = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  initial begin
    int ph;
    logic w, r;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00; err_clr = 1'b0;

    // Reset with requests, fill 01..08, full R/W with AA, drain, empty R/W with 55
    tbl[0] = mk(1'b1, 1'b1, 1'b1, 8'hFF, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 8'hEE, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 8; k++)
      tbl[k+1] = mk(1'b0, 1'b1, 1'b0, 8'(k), k, k == 8, 1'b0, k >= 6, k <= 2, 1'b0, 8'h00);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 8'hAA, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    for (int k = 1; k <= 7; k++)
      tbl[10+k] = mk(1'b0, 1'b0, 1'b1, 8'h00, 8 - k, 1'b0, 1'b0, (8 - k) >= 6, (8 - k) <= 2, 1'b1, 8'(k + 1));
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    tbl[19] = mk(1'b0, 1'b1, 1'b1, 8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
    tbl[20] = mk(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);

    for (int i = 0; i < 22; i++) begin
      cycle(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].wd, 1'b0);
      chk($sformatf("tbl%0d count", i), cnt1, tbl[i].cnt);
      chk($sformatf("tbl%0d full", i), full1, tbl[i].full);
      chk($sformatf("tbl%0d empty", i), empty1, tbl[i].empty);
      chk($sformatf("tbl%0d afull", i), af1, tbl[i].af);
      chk($sformatf("tbl%0d aempty", i), ae1, tbl[i].ae);
      chk($sformatf("tbl%0d valid", i), vld1, tbl[i].vld);
      chk($sformatf("tbl%0d rdata", i), rdd1, tbl[i].rdd);
    end
    chk("udf_after_empty_rw", udf1, int'(ERR_ON));

    // Overflow: 9 writes into the 8-deep FIFO drop the last one
    cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h10 + k), 1'b0);
    chk("ovf_after_9", ovf1, int'(ERR_ON));
    chk("cnt_after_9", cnt1, 8);
    cycle(1'b0, 1'b1, 1'b0, 8'h99, 1'b1);
    chk("ovf_set_beats_clr", ovf1, int'(ERR_ON));
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", ovf1, 0);
    for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("last_drained", rdd1, 8'h17);

    // Mid-operation reset discards entries
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h30 + k), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
    chk("rst_mid_count", cnt1, 0);
    cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("rst_mid_no_valid", vld1, 0);

    // Random wrap stress, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 1000; n++) begin
      ph = n / 125;
      if (ph % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      cycle(($urandom_range(0, 299) == 0), w, r, 8'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
